// File: rtl/conv3x3_selu_channel.sv
// 3x3 "same" convolution (zero pad 1) on a raster pixel stream, followed by
// arithmetic-shift quantization, saturation and a SELU lookup.

module conv3x3_selu_tap #(
  parameter bit IS_SIGNED = 1'b0
)(
  input  logic               [7:0]  px,
  input  logic               [7:0]  w,
  input  logic                      keep,
  output logic signed        [16:0] prod
);
  logic signed [8:0] x;
  assign x    = keep ? (IS_SIGNED ? {px[7], px} : {1'b0, px}) : 9'sd0;
  assign prod = 17'(x) * 17'($signed(w));
endmodule

module conv3x3_selu_channel #(
  parameter int IMG_W           = 28,
  parameter int IMG_H           = 28,
  parameter int INPUT_IS_SIGNED = 0,
  parameter int QUANT_SHIFT     = 7
)(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  input  logic [71:0] weights,
  output logic        out_valid,
  output logic [7:0]  out_data
);
  localparam int NPIX = IMG_W * IMG_H;
  localparam int KMAX = IMG_W * (IMG_H + 1);
  localparam int KW   = $clog2(KMAX + 1);
  localparam int CW   = $clog2(IMG_W);
  localparam int RW   = $clog2(IMG_H);

  // Smallest |x| at which round(0.0507*x) / the negative SELU magnitude
  // reaches each successive integer; the ROM is the count of thresholds met.
  localparam int POS_T [6]  = '{10, 30, 50, 70, 89, 109};
  localparam int NEG_T [28] = '{1, 1, 2, 3, 3, 4, 5, 5, 6, 7, 8, 9, 10, 11,
                                12, 13, 15, 16, 18, 19, 21, 24, 26, 29, 33,
                                38, 46, 61};

  function automatic logic [7:0] selu_rom(input logic [7:0] x);
    int v, n;
    v = 0;
    if (!x[7]) begin
      n = int'(x);
      for (int m = 0; m < 6; m++) if (n >= POS_T[m]) v++;
      v = n + v;
      if (v > 127) v = 127;
    end else begin
      n = 256 - int'(x);
      for (int m = 0; m < 28; m++) if (n >= NEG_T[m]) v--;
    end
    return v[7:0];
  endfunction

  logic [KW-1:0]           k;
  logic                    flushing, step, trig;
  logic [CW-1:0]           cc;
  logic [RW-1:0]           cr;
  logic [7:0]              px;
  logic [IMG_W-1:0][7:0]   lb0, lb1;
  logic [2:0][2:0][7:0]    win;
  logic                    pad_top, pad_bot, pad_left, pad_right;
  logic [2:0]              row_keep, col_keep;
  logic [2:0]              vld_pipe;
  logic signed [16:0]      prod [9];
  logic signed [31:0]      sum, acc, q;
  logic [7:0]              qs;

  assign in_ready = !flushing;
  assign step     = flushing || in_valid;
  assign px       = flushing ? 8'd0 : in_data;
  assign trig     = k >= KW'(IMG_W + 1);

  // k is the stream index; (cr,cc) is the output center owed at the next trigger.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k        <= '0;
      flushing <= 1'b0;
      cc       <= '0;
      cr       <= '0;
    end else if (step) begin
      if (k == KW'(KMAX)) begin
        k        <= '0;
        flushing <= 1'b0;
      end else begin
        k <= k + 1'b1;
        if (k == KW'(NPIX - 1)) flushing <= 1'b1;
      end
      if (trig) begin
        if (cc == CW'(IMG_W - 1)) begin
          cc <= '0;
          cr <= (cr == RW'(IMG_H - 1)) ? '0 : cr + 1'b1;
        end else begin
          cc <= cc + 1'b1;
        end
      end
    end
  end

  // Stage 1: line buffers feed the right-hand column of the window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lb0       <= '0;
      lb1       <= '0;
      win       <= '0;
      pad_top   <= 1'b0;
      pad_bot   <= 1'b0;
      pad_left  <= 1'b0;
      pad_right <= 1'b0;
    end else if (step) begin
      lb1 <= {lb1[IMG_W-2:0], px};
      lb0 <= {lb0[IMG_W-2:0], lb1[IMG_W-1]};
      for (int r = 0; r < 3; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= win[r][2];
      end
      win[2][2] <= px;
      win[1][2] <= lb1[IMG_W-1];
      win[0][2] <= lb0[IMG_W-1];
      pad_top   <= cr == '0;
      pad_bot   <= cr == RW'(IMG_H - 1);
      pad_left  <= cc == '0;
      pad_right <= cc == CW'(IMG_W - 1);
    end
  end

  assign row_keep = {~pad_bot, 1'b1, ~pad_top};
  assign col_keep = {~pad_right, 1'b1, ~pad_left};

  for (genvar i = 0; i < 3; i++) begin : g_row
    for (genvar j = 0; j < 3; j++) begin : g_col
      conv3x3_selu_tap #(.IS_SIGNED(INPUT_IS_SIGNED != 0)) u_tap (
        .px   (win[i][j]),
        .w    (weights[(3*i+j)*8 +: 8]),
        .keep (row_keep[i] & col_keep[j]),
        .prod (prod[3*i+j])
      );
    end
  end

  always_comb begin
    sum = '0;
    for (int t = 0; t < 9; t++) sum = sum + 32'(prod[t]);
  end

  assign q  = acc >>> QUANT_SHIFT;
  assign qs = (q > 127) ? 8'h7f : (q < -128) ? 8'h80 : q[7:0];

  // Stages 2 and 3 run every cycle; only out_data is gated so it holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      acc      <= '0;
      out_data <= '0;
    end else begin
      vld_pipe <= {vld_pipe[1:0], step && trig};
      acc      <= sum;
      if (vld_pipe[1]) out_data <= selu_rom(qs);
    end
  end

  assign out_valid = vld_pipe[2];
endmodule

// File: tb/tb_conv3x3_selu_channel.sv
// Bench for conv3x3_selu_channel: two 4x4 instances (unsigned/shift 0 and
// signed/shift 2) share one stimulus stream and are scored against a model.
module tb_conv3x3_selu_channel;
  localparam int W = 4, H = 4, NPIX = W * H;
  localparam int SH0 = 0, SH1 = 2;

  logic        clk = 0, rst_n = 0, in_valid = 0;
  logic [7:0]  in_data = 0;
  logic [71:0] weights = '0;
  logic        in_ready0, in_ready1, ov0, ov1;
  logic [7:0]  od0, od1;

  int checks = 0, errors = 0, cyc = 0;
  logic [7:0] pix [H][W];
  int wt [3][3];
  typedef struct { int t; int d0; int d1; } exp_t;
  exp_t expq[$];
  int   got0[$];
  int   last0, last1;

  conv3x3_selu_channel #(.IMG_W(W), .IMG_H(H), .INPUT_IS_SIGNED(0), .QUANT_SHIFT(SH0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .in_data(in_data), .weights(weights), .out_valid(ov0), .out_data(od0));
  conv3x3_selu_channel #(.IMG_W(W), .IMG_H(H), .INPUT_IS_SIGNED(1), .QUANT_SHIFT(SH1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .in_data(in_data), .weights(weights), .out_valid(ov1), .out_data(od1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int selu_ref(int x);
    real f;
    int  y;
    if (x >= 0) begin
      y = int'($floor(1.0507 * x + 0.5));
      return (y > 127) ? 127 : y;
    end
    f = 16.0 * 1.0507 * 1.67326 * ($exp(x / 16.0) - 1.0);
    return -int'($floor(-f + 0.5));
  endfunction

  function automatic int model(int r, int c, bit sgn, int sh);
    longint s = 0;
    int p, q;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++)
        if (r+dr >= 0 && r+dr < H && c+dc >= 0 && c+dc < W) begin
          p = sgn ? int'($signed(pix[r+dr][c+dc])) : int'(pix[r+dr][c+dc]);
          s += p * wt[dr+1][dc+1];
        end
    q = int'(s >>> sh);
    if (q > 127)  q = 127;
    if (q < -128) q = -128;
    return selu_ref(q);
  endfunction

  // Step k at edge e triggers output center k-W-1, due two edges later.
  task automatic step_trig(input int k, input int e);
    exp_t x;
    int idx;
    if (k >= W + 1) begin
      idx  = k - W - 1;
      x.t  = e + 2;
      x.d0 = model(idx / W, idx % W, 1'b0, SH0);
      x.d1 = model(idx / W, idx % W, 1'b1, SH1);
      expq.push_back(x);
    end
  endtask

  task automatic run_frame(input int gap_pct, input int stop_after);
    int k;
    k = 0;
    while (k < NPIX) begin
      @(negedge clk);
      chk("in_ready_frame", int'(in_ready0), 1);
      chk("in_ready_frame_s", int'(in_ready1), 1);
      if (stop_after >= 0 && k == stop_after) begin
        in_valid = 0;
        return;
      end
      if ($urandom_range(99) < gap_pct) begin
        in_valid = 0;
        in_data  = 8'($urandom);
      end else begin
        in_valid = 1;
        in_data  = pix[k / W][k % W];
        step_trig(k, cyc + 1);
        k++;
      end
    end
    for (int j = 0; j <= W; j++) begin
      @(negedge clk);
      chk("in_ready_flush", int'(in_ready0), 0);
      chk("in_ready_flush_s", int'(in_ready1), 0);
      in_valid = (j < W) ? 1'($urandom_range(1)) : 1'b0;
      in_data  = 8'($urandom);
      step_trig(NPIX + j, cyc + 1);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (expq.size() > 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", expq.size(), 0);
    expq.delete();
    @(negedge clk);
  endtask

  task automatic set_w();
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        weights[(3*i+j)*8 +: 8] = 8'(wt[i][j]);
  endtask

  task automatic fill_w(input int v);
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) wt[i][j] = v;
  endtask

  task automatic fill_pix(input int maxv);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) pix[r][c] = 8'($urandom_range(maxv));
  endtask

  always @(negedge clk) begin : cmp
    bit due;
    if (!rst_n) begin
      last0 = 0;
      last1 = 0;
    end else begin
      due = (expq.size() > 0) && (expq[0].t == cyc);
      chk("out_valid", int'(ov0), int'(due));
      chk("out_valid_s", int'(ov1), int'(due));
      if (due) begin
        chk("out_data", int'($signed(od0)), expq[0].d0);
        chk("out_data_s", int'($signed(od1)), expq[0].d1);
        got0.push_back(int'($signed(od0)));
        last0 = expq[0].d0;
        last1 = expq[0].d1;
        void'(expq.pop_front());
      end else begin
        chk("out_hold", int'($signed(od0)), last0);
        chk("out_hold_s", int'($signed(od1)), last1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_out_valid", int'(ov0), 0);
    chk("rst_out_data", int'(od0), 0);
    chk("rst_in_ready", int'(in_ready0), 1);
    chk("pin_selu_16", selu_ref(16), 17);
    chk("pin_selu_m1", selu_ref(-1), -2);
    chk("pin_selu_m16", selu_ref(-16), -18);
    chk("pin_selu_m64", selu_ref(-64), -28);
    chk("pin_selu_m128", selu_ref(-128), -28);
    chk("pin_selu_127", selu_ref(127), 127);
    @(negedge clk);
    rst_n = 1;

    // Identity kernel exposes the SELU table directly.
    fill_w(0);
    wt[1][1] = 1;
    set_w();
    fill_pix(255);
    pix[0][0] = 0; pix[0][1] = 1; pix[0][2] = 16; pix[0][3] = 200;
    got0.delete();
    run_frame(0, -1);
    drain();
    chk("id_count", got0.size(), NPIX);
    chk("id_0", got0[0], 0);
    chk("id_1", got0[1], 1);
    chk("id_16", got0[2], 17);
    chk("id_200", got0[3], 127);

    // All-ones: padding yields 4 / 6 / 9.
    fill_w(1);
    set_w();
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) pix[r][c] = 8'd1;
    got0.delete();
    run_frame(0, -1);
    drain();
    chk("pad_corner", got0[0], 4);
    chk("pad_edge", got0[1], 6);
    chk("pad_inner", got0[5], 9);
    chk("pad_corner_br", got0[15], 4);

    // Negative weights saturate to the bottom of the SELU curve.
    fill_w(-1);
    set_w();
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) pix[r][c] = 8'd16;
    got0.delete();
    run_frame(0, -1);
    drain();
    chk("neg_corner", got0[0], -28);
    chk("neg_inner", got0[5], -28);

    // Random weights and pixels, bubbles, back-to-back frames.
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++) wt[i][j] = $urandom_range(6) - 3;
      set_w();
      fill_pix((f % 2 == 0) ? 40 : 255);
      run_frame(30, -1);
      fill_pix(60);
      run_frame(0, -1);
      fill_pix(255);
      run_frame(50, -1);
      drain();
    end

    // Reset mid-frame, then a full frame with bubbles.
    fill_pix(255);
    run_frame(0, 7);
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("midrst_out_valid", int'(ov0), 0);
    chk("midrst_out_valid_s", int'(ov1), 0);
    chk("midrst_out_data", int'(od0), 0);
    chk("midrst_in_ready", int'(in_ready0), 1);
    expq.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    fill_pix(255);
    got0.delete();
    run_frame(25, -1);
    drain();
    chk("midrst_count", got0.size(), NPIX);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/conv3x3_selu_channel.md
Name: conv3x3_selu_channel

Overview:
- Single-input, single-output-channel 3x3 "same" convolution engine with zero padding of 1, followed by quantization and a SELU lookup activation.
- Serves as the per-channel building block of the CNN conv layers; the layer sums many of these kernels.
- Pixel path: raster-scan pixel stream → two-row line buffer → 3x3 window → 9-tap MAC → shift/saturate → 256-entry SELU LUT.

Parameters:
- IMG_W, 28, image width in pixels (≥3).
- IMG_H, 28, image height in rows (≥3).
- INPUT_IS_SIGNED, 0: 0 = pixels are unsigned 0..255 (zero-extended); 1 = pixels are signed two's complement.
- QUANT_SHIFT, 7, arithmetic right shift applied to the MAC sum before saturation.

Ports:
- clk, input, 1: clock.
- rst_n, input, 1: reset, asynchronous, active-low.
- in_valid, input, 1: pixel present; accepted when in_valid && in_ready.
- in_ready, output, 1: low only during the end-of-frame flush.
- in_data, input, 8: pixel, raster order (row 0 col 0 first).
- weights, input, 72: signed 8-bit weights w00..w22 (row-major); w00 = [7:0], w01 = [15:8], …, w22 = [71:64]. Must be static during a frame.
- out_valid, output, 1: one-cycle pulse per output pixel.
- out_data, output, 8: signed SELU result.

Behaviour:
Reset:
- Clears all counters, line buffers, window and pipeline registers.
- out_valid = 0, out_data = 0, in_ready = 1.
- Reset mid-frame discards the frame; the next accepted pixel is row 0 col 0.

Stream index and emission:
- Stream index k counts accepted pixels, 0..IMG_W*IMG_H-1.
- Flush positions k = IMG_W*IMG_H .. IMG_W*(IMG_H+1) inject pixel value 0.
- Output center (r,c) is triggered at k = (r+1)*IMG_W + c + 1.
- Result: exactly IMG_W*IMG_H outputs per frame, in raster order.

Flush:
- Starts the cycle after the last pixel of the frame is accepted.
- Lasts IMG_W+1 cycles. in_ready = 0 throughout, and in_valid is ignored.
- Afterwards k returns to 0 and in_ready = 1.
- Gaps (in_valid low) are allowed anywhere outside the flush; the window then holds its state.

Line buffer / window:
- Two IMG_W-deep row delays and a 3x3 shift window, all advancing only on an accept or flush step.
- Line buffers are not cleared between frames.

Padding masks (forced to 0 before the MAC):
- Top row of window when r = 0.
- Bottom row when r = IMG_H-1.
- Left column when c = 0.
- Right column when c = IMG_W-1. This also hides row-wrap data.

MAC:
- Each pixel is extended to 9-bit signed per INPUT_IS_SIGNED and multiplied by its signed weight.
- Nine products are summed into a 32-bit signed result; no overflow is possible.

Quantize:
- q = sum >>> QUANT_SHIFT, arithmetic.
- Saturate q to [-128, 127].

SELU:
- Fixed-point input/output scale is 1/16.
- x ≥ 0: y = round(1.0507·x), saturated to 127.
- x < 0: y = round(16·1.0507·1.67326·(exp(x/16) − 1)).
- Rounding is half away from zero.
- Implemented as a 256-entry constant ROM. Key entries: 0→0, 1→1, 16→17, 127→127, −1→−2, −16→−18, −64→−28, −128→−28.

Pipeline and latency:
- Stage 1: window register. Stage 2: MAC register. Stage 3: quantize+SELU register driving out_data.
- out_valid pulses exactly 3 cycles after the triggering step, including flush steps.
- Stages 2 and 3 advance every cycle.
- out_data holds its last value when out_valid = 0.

Test Plan:
1. Identity/SELU: IMG_W=IMG_H=4, QUANT_SHIFT=0, w11=1 and others 0, pixels 0,1,16,200,… → outputs 0,1,17,127 in raster order; 16 out_valid pulses.
2. Padding: all weights 1, all pixels 1, shift 0 → corners 4, edges 6, interior 9 (SELU gives 4,6,9).
3. Negative saturation: all weights 0xFF, pixels 16, shift 0 → interior sum −144 saturates to −128 → −28; corners (−64) → −28.
4. Timing: 4x4 frame streamed back-to-back → first out_valid 3 cycles after the 6th pixel is accepted; in_ready low for exactly 5 cycles after the 16th pixel; last out_valid 3 cycles after the final flush step.
5. Gaps and back-to-back frames: random in_valid bubbles, then a second frame started right after the flush → results bit-identical to the gap-free run; no leakage between frames.
6. Reset mid-frame (after 7 pixels) → out_valid = 0 immediately; a new full frame yields the correct 16 outputs.
